nios2_c_irq_ctrl: RTL
=====================

NIOS2_C_IRQ_CTRL -- requirements
Module: nios2_c_irq_ctrl

Interface
REQ-001 SHALL have parameter N_IRQ, default 8, meaning number of interrupt sources; legal range 1..16.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port address, input, 3, Avalon-MM register word address.
REQ-005 SHALL have port chipselect, input, 1, slave select.
REQ-006 SHALL have port write_n, input, 1, active-low write strobe.
REQ-007 SHALL have port writedata, input, 16, write data.
REQ-008 SHALL have port readdata, output, 16, registered read data.
REQ-009 SHALL have port irq_in, input, N_IRQ, synchronous interrupt requests from timers and peripherals, bit 0 = timer irq.
REQ-010 SHALL have port irq, output, 1, registered aggregated interrupt to the CPU.

Function
REQ-011 SHALL decode a write as chipselect && !write_n at the given address; writes to bits at or above N_IRQ SHALL be ignored.
REQ-012 SHALL register readdata every clock from the address mux, independent of chipselect, giving 1-cycle read latency; unimplemented bits and addresses 6..7 SHALL read 0.
REQ-013 SHALL map registers: 0 PENDING (R, W1C), 1 MASK (RW), 2 EDGE (RW, 1=rising-edge, 0=level), 3 ACTIVE (R), 4 SWSET (W, reads 0), 5 EVCOUNT (R, any write clears).
REQ-014 SHALL keep irq_d, a 1-cycle delayed copy of irq_in, and form rise = irq_in & ~irq_d.
REQ-015 SHALL form per-bit set = (EDGE ? rise : irq_in) | (SWSET write ? writedata : 0).
REQ-016 SHALL update pending <= (pending & ~clr) | set, where clr = writedata on a PENDING write; set SHALL win when set and clr coincide on a bit.
REQ-017 SHALL re-assert a level-mode pending bit on the cycle after a W1C while irq_in stays high.
REQ-018 SHALL compute active = pending & MASK and drive irq <= |active, so an irq_in rise at edge t gives pending at t+1 and irq at t+2.
REQ-019 SHALL return ACTIVE as bit15 = |active and bits3:0 = lowest set index of active (index 0 highest priority), 0 when none.
REQ-020 SHALL retain pending bits across MASK changes; unmasking a pending bit SHALL raise irq one cycle later.
REQ-021 SHALL leave irq_d and pending untouched on EDGE changes.
REQ-022 SHALL increment EVCOUNT by 1 in each cycle in which at least one pending bit goes 0->1, saturating at 0xFFFF.
REQ-023 SHALL give an EVCOUNT clear priority over a same-cycle increment, leaving EVCOUNT 0.

Reset
REQ-024 SHALL, on reset, asynchronously clear pending, MASK, EDGE, irq_d, EVCOUNT, readdata and irq to 0.
REQ-025 SHALL, on reset asserted mid-operation, drop irq to 0 immediately and discard in-flight events.
REQ-026 SHALL have no pending bits set after reset release until a new set condition, so level sources held high re-pend at the first clock.

Structure
REQ-027 SHALL place register address constants, the N_IRQ maximum (16) and the ACTIVE valid-bit position (15) in shared package nios2_c_irq_pkg.
REQ-028 SHALL implement the lowest-index priority encoder as sub-module nios2_c_irq_prio_enc (N_IRQ in; valid plus 4-bit index out, combinational).

Verification
REQ-029 SHALL cover: EDGE=0x01, MASK=0x01, pulse irq_in[0] for 1 cycle at t -> PENDING=0x0001 at t+1, irq=1 at t+2, EVCOUNT=1; W1C 0x0001 -> irq=0 two cycles later.
REQ-030 SHALL cover: level mode, MASK=0x04, irq_in[2] held high, W1C 0x0004 -> PENDING bit 2 reads 1 again, irq stays 1; drop irq_in[2] then W1C -> irq=0.
REQ-031 SHALL cover: MASK=0x00, SWSET 0x0030 -> irq stays 0, ACTIVE=0x0000; MASK=0x20 -> irq=1 next cycle, ACTIVE=0x8005.
REQ-032 SHALL cover: edge mode, rise on bit 1 in the same cycle as W1C 0x0002 -> bit 1 remains pending.
REQ-033 SHALL cover: EVCOUNT forced to saturation by 65536 events -> reads 0xFFFF; write to address 5 coincident with a new event -> reads 0x0000.
REQ-034 SHALL cover: reset asserted while irq=1 and EVCOUNT=3 -> irq, readdata, all registers 0 without a clock edge.

Source files
------------

// File: rtl/nios2_c_irq_pkg.sv
// Shared constants, register map and helpers for the Nios II interrupt controller.
package nios2_c_irq_pkg;

    localparam int DATA_W           = 16;
    localparam int ADDR_W           = 3;
    localparam int IRQ_MAX          = 16;
    localparam int ACTIVE_VALID_BIT = 15;
    localparam logic [DATA_W-1:0] EVCOUNT_MAX = 16'hFFFF;

    // Register word addresses; 6 and 7 are unimplemented and read as zero.
    typedef enum logic [ADDR_W-1:0] {
        REG_PENDING = 3'd0,
        REG_MASK    = 3'd1,
        REG_EDGE    = 3'd2,
        REG_ACTIVE  = 3'd3,
        REG_SWSET   = 3'd4,
        REG_EVCOUNT = 3'd5
    } reg_addr_e;

    // Bit mask covering the implemented interrupt sources [n-1:0].
    function automatic logic [DATA_W-1:0] impl_mask(input int n);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/nios2_c_irq_ctrl_if.sv
// Avalon-MM register port of the interrupt controller.
interface nios2_c_irq_ctrl_if;
    import nios2_c_irq_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    // CPU / bus side
    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    // Controller side
    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/nios2_c_irq_prio_enc.sv
// Lowest-index-first priority encoder: index 0 has the highest priority.
module nios2_c_irq_prio_enc #(
    parameter int N_IRQ = 8
) (
    input  logic [N_IRQ-1:0] req,
    output logic             valid,
    output logic [3:0]       index
);

    // Scan from the top down so the lowest set bit is the last one to write.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        valid = 1'b0;
        index = 4'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                index = 4'(i);
            end
        end
    end

endmodule

// File: rtl/nios2_c_irq_ctrl.sv
// Interrupt aggregator: per-source level/edge capture, masking, priority
// readout and an event counter behind a small Avalon-MM register file.
module nios2_c_irq_ctrl
    import nios2_c_irq_pkg::*;
#(
    parameter int N_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset,
    nios2_c_irq_ctrl_if.slave  bus,
    input  logic [N_IRQ-1:0]   irq_in,
    output logic               irq
);

    // Bits at or above N_IRQ are held at constant zero everywhere.
    localparam logic [DATA_W-1:0] IMPL_MASK = impl_mask(N_IRQ);

    if (N_IRQ < 1 || N_IRQ > IRQ_MAX) begin : g_bad_n_irq
        $error("nios2_c_irq_ctrl: N_IRQ must be in 1..16");
    end

    logic [DATA_W-1:0] irq_in_w;
    logic [DATA_W-1:0] irq_d;
    logic [DATA_W-1:0] pending_q;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] edge_q;
    logic [DATA_W-1:0] evcount_q;

    logic [DATA_W-1:0] wdata_impl;
    logic [DATA_W-1:0] rise;
    logic [DATA_W-1:0] set_vec;
    logic [DATA_W-1:0] clr_vec;
    logic [DATA_W-1:0] pending_nxt;
    logic [DATA_W-1:0] active;
    logic [DATA_W-1:0] rd_mux;

    logic              wr_en;
    logic              wr_pending;
    logic              wr_mask;
    logic              wr_edge;
    logic              wr_swset;
    logic              wr_evcount;
    logic              new_event;
    logic              act_valid;
    logic [3:0]        act_index;

    assign irq_in_w   = DATA_W'(irq_in);
    assign wdata_impl = bus.writedata & IMPL_MASK;

    assign wr_en      = bus.chipselect & ~bus.write_n;
    assign wr_pending = wr_en && (bus.address == REG_PENDING);
    assign wr_mask    = wr_en && (bus.address == REG_MASK);
    assign wr_edge    = wr_en && (bus.address == REG_EDGE);
    assign wr_swset   = wr_en && (bus.address == REG_SWSET);
    assign wr_evcount = wr_en && (bus.address == REG_EVCOUNT);

    // Set sources win over a same-cycle W1C, so a held level re-pends immediately.
    assign rise        = irq_in_w & ~irq_d;
    assign set_vec     = (edge_q & rise) | (~edge_q & irq_in_w) | (wr_swset ? wdata_impl : '0);
    assign clr_vec     = wr_pending ? wdata_impl : '0;
    assign pending_nxt = (pending_q & ~clr_vec) | set_vec;
    assign new_event   = |(pending_nxt & ~pending_q);
    assign active      = pending_q & mask_q;

    nios2_c_irq_prio_enc #(
        .N_IRQ (N_IRQ)
    ) u_prio_enc (
        .req   (active[N_IRQ-1:0]),
        .valid (act_valid),
        .index (act_index)
    );

    // Software-configurable MASK and EDGE registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: state is updated with <= so every register samples pre-edge values.
            mask_q <= '0;
            edge_q <= '0;
        end else begin
            if (wr_mask) mask_q <= wdata_impl;
            if (wr_edge) edge_q <= wdata_impl;
        end
    end

    // Input history for edge detection and the pending latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_d     <= '0;
            pending_q <= '0;
        end else begin
            irq_d     <= irq_in_w;
            pending_q <= pending_nxt;
        end
    end

    // Saturating count of cycles with at least one new pending bit; a write clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evcount_q <= '0;
        end else if (wr_evcount) begin
            evcount_q <= '0;
        end else if (new_event && (evcount_q != EVCOUNT_MAX)) begin
            evcount_q <= evcount_q + 16'd1;
        end
    end

    // Register read mux; SWSET and unimplemented addresses read zero.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            REG_PENDING: rd_mux = pending_q;
            REG_MASK:    rd_mux = mask_q;
            REG_EDGE:    rd_mux = edge_q;
            REG_ACTIVE: begin
                rd_mux[ACTIVE_VALID_BIT] = act_valid;
                rd_mux[3:0]              = act_index;
            end
            REG_EVCOUNT: rd_mux = evcount_q;
            default:     rd_mux = '0;
        endcase
    end

    // Registered outputs: read data every cycle, aggregated irq from masked pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            bus.readdata <= rd_mux;
            irq          <= |active;
        end
    end

endmodule
